// File: rtl/hilo_ctrl_pkg.sv
// hilo_ctrl_pkg: shared constants and helpers for the HI/LO controller.
//   RstEnable / WriteEnable / WriteDisable mirror the shared defines header.
//   fwd_src_e / fwd_pick select the youngest valid forwarding source.
package hilo_ctrl_pkg;

  localparam int   REG_W        = 32;    // RegBus width
  localparam logic RstEnable    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam int   NUM_SLOTS    = 2;

  typedef enum logic [2:0] {
    SRC_MEM2,
    SRC_MEM1,
    SRC_WB2,
    SRC_WB1,
    SRC_ARCH
  } fwd_src_e;

  // Youngest first: MEM beats WB, slot 2 beats slot 1 within a stage.
  function automatic fwd_src_e fwd_pick(input logic [NUM_SLOTS-1:0] mem_v,
                                        input logic [NUM_SLOTS-1:0] wb_v);
    if (mem_v[1])     return SRC_MEM2;
    else if (mem_v[0]) return SRC_MEM1;
    else if (wb_v[1])  return SRC_WB2;
    else if (wb_v[0])  return SRC_WB1;
    else               return SRC_ARCH;
  endfunction

endpackage

// File: rtl/hilo_ctrl_if.sv
// hilo_ctrl_if: EX-side write requests, pipeline control and HI/LO results.
//   master: pipeline side (drives requests/control, reads HI/LO)
//   slave : hilo_ctrl side
interface hilo_ctrl_if #(parameter int W = 32);
  logic         whilo1_i;
  logic [W-1:0] hi1_i, lo1_i;
  logic         whilo2_i;
  logic [W-1:0] hi2_i, lo2_i;
  logic         stall_ex_i, stall_mem_i, flush_i;
  logic         mem_kill1_i, mem_kill2_i;
  logic [W-1:0] hi_o, lo_o;
  logic [W-1:0] hi_arch_o, lo_arch_o;

  modport master (
    output whilo1_i, hi1_i, lo1_i, whilo2_i, hi2_i, lo2_i,
    output stall_ex_i, stall_mem_i, flush_i, mem_kill1_i, mem_kill2_i,
    input  hi_o, lo_o, hi_arch_o, lo_arch_o
  );

  modport slave (
    input  whilo1_i, hi1_i, lo1_i, whilo2_i, hi2_i, lo2_i,
    input  stall_ex_i, stall_mem_i, flush_i, mem_kill1_i, mem_kill2_i,
    output hi_o, lo_o, hi_arch_o, lo_arch_o
  );
endinterface

// File: rtl/hilo_ctrl_stage.sv
// hilo_stage: one pipeline stage (MEM or WB) holding both issue slots.
//   clk, rst      : clock, async active-high reset
//   load          : capture in_* this edge
//   clear         : drop both entries (higher priority than load)
//   kill[s]       : suppress slot s while loading
//   in_v/in_hi/in_lo : incoming entries, out v/hi/lo : held entries
// Data of an invalid entry is kept at zero.
module hilo_stage
  import hilo_ctrl_pkg::*;
#(
  parameter int W = REG_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic                        clear,
  input  logic [NUM_SLOTS-1:0]        kill,
  input  logic [NUM_SLOTS-1:0]        in_v,
  input  logic [NUM_SLOTS-1:0][W-1:0] in_hi,
  input  logic [NUM_SLOTS-1:0][W-1:0] in_lo,
  output logic [NUM_SLOTS-1:0]        v,
  output logic [NUM_SLOTS-1:0][W-1:0] hi,
  output logic [NUM_SLOTS-1:0][W-1:0] lo
);

  logic [NUM_SLOTS-1:0] take;
  assign take = in_v & ~kill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      v  <= '0;
      hi <= '0;
      lo <= '0;
    end else if (clear) begin
      v  <= '0;
      hi <= '0;
      lo <= '0;
    end else if (load) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        v[s]  <= take[s];
        hi[s] <= take[s] ? in_hi[s] : '0;
        lo[s] <= take[s] ? in_lo[s] : '0;
      end
    end
  end

endmodule

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: architectural HI/LO pair for the dual-issue pipeline.
//   clk, rst : clock, async active-high reset
//   bus      : hilo_ctrl_if.slave -- per-slot EX write requests, stall/flush,
//              MEM kills; returns forwarded HI/LO (hi_o/lo_o) and
//              architectural HI/LO (hi_arch_o/lo_arch_o).
// Build option: HILO_FWD_EN defined builds the MEM/WB forwarding mux;
// otherwise hi_o/lo_o are the architectural registers.
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int W = REG_W
) (
  input  logic        clk,
  input  logic        rst,
  hilo_ctrl_if.slave  bus
);

  logic [NUM_SLOTS-1:0]        mem_v, wb_v;
  logic [NUM_SLOTS-1:0][W-1:0] mem_hi, mem_lo, wb_hi, wb_lo;
  logic [W-1:0]                arch_hi, arch_lo;

  // Stage control, priority flush > stall_mem > stall_ex > advance.
  // stall_mem holds MEM and bubbles WB; stall_ex bubbles MEM while WB
  // still drains MEM.
  logic mem_load, mem_clear, wb_clear;
  assign mem_load  = ~bus.stall_mem_i;
  assign mem_clear = bus.flush_i | (bus.stall_ex_i & ~bus.stall_mem_i);
  assign wb_clear  = bus.flush_i | bus.stall_mem_i;

  // An older-slot exception also kills the younger slot.
  logic [NUM_SLOTS-1:0] wb_kill;
  assign wb_kill = {bus.mem_kill1_i | bus.mem_kill2_i, bus.mem_kill1_i};

  hilo_stage #(.W(W)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .load  (mem_load),
    .clear (mem_clear),
    .kill  ({WriteDisable, WriteDisable}),
    .in_v  ({bus.whilo2_i, bus.whilo1_i}),
    .in_hi ({bus.hi2_i, bus.hi1_i}),
    .in_lo ({bus.lo2_i, bus.lo1_i}),
    .v     (mem_v),
    .hi    (mem_hi),
    .lo    (mem_lo)
  );

  hilo_stage #(.W(W)) u_wb (
    .clk   (clk),
    .rst   (rst),
    .load  (WriteEnable),
    .clear (wb_clear),
    .kill  (wb_kill),
    .in_v  (mem_v),
    .in_hi (mem_hi),
    .in_lo (mem_lo),
    .v     (wb_v),
    .hi    (wb_hi),
    .lo    (wb_lo)
  );

  // Commit in program order: slot 2 is younger, so its write lands last.
  // WB commits on every edge, including flush and stall edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      arch_hi <= '0;
      arch_lo <= '0;
    end else if (wb_v[1]) begin
      arch_hi <= wb_hi[1];
      arch_lo <= wb_lo[1];
    end else if (wb_v[0]) begin
      arch_hi <= wb_hi[0];
      arch_lo <= wb_lo[0];
    end
  end

  assign bus.hi_arch_o = arch_hi;
  assign bus.lo_arch_o = arch_lo;

`ifdef HILO_FWD_EN
  // Killed MEM entries still forward; their consumers get flushed anyway.
  fwd_src_e     fwd_src;
  logic [W-1:0] fwd_hi, fwd_lo;
  assign fwd_src = fwd_pick(mem_v, wb_v);

  always_comb begin
    fwd_hi = arch_hi;
    fwd_lo = arch_lo;
    case (fwd_src)
      SRC_MEM2: begin fwd_hi = mem_hi[1]; fwd_lo = mem_lo[1]; end
      SRC_MEM1: begin fwd_hi = mem_hi[0]; fwd_lo = mem_lo[0]; end
      SRC_WB2:  begin fwd_hi = wb_hi[1];  fwd_lo = wb_lo[1];  end
      SRC_WB1:  begin fwd_hi = wb_hi[0];  fwd_lo = wb_lo[0];  end
      default:  ;
    endcase
  end

  assign bus.hi_o = fwd_hi;
  assign bus.lo_o = fwd_lo;
`else
  // No bypass: the pipeline controller interlocks readers behind writers.
  assign bus.hi_o = arch_hi;
  assign bus.lo_o = arch_lo;
`endif

endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

Owns the architectural HI/LO register pair for the dual-issue pipeline. It consumes the HI/LO write requests that both execute slots emit (`whilo`/`hi`/`lo` per slot) and carries them through MEM and WB. It commits them in program order and returns the forwarded current HI/LO value to both execute slots for MFHI/MFLO and partial MTHI/MTLO merges. Sits beside the MEM/WB pipeline registers and is driven by the pipeline controller's stall and flush signals.

## Interface
Parameters:
- `W`, 32, data width of HI and LO.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset (`RstEnable` = 1'b1).
- `whilo1_i`  in  1  slot-1 (older) EX write request.
- `hi1_i`, `lo1_i`  in  W  slot-1 HI/LO values to write.
- `whilo2_i`  in  1  slot-2 (younger) EX write request.
- `hi2_i`, `lo2_i`  in  W  slot-2 HI/LO values to write.
- `stall_ex_i`  in  1  EX stalled and MEM advancing: a bubble enters MEM.
- `stall_mem_i`  in  1  MEM stalled: EX→MEM and MEM contents hold, and a bubble enters WB.
- `flush_i`  in  1  exception/ERET flush: clears MEM and WB entries.
- `mem_kill1_i`  in  1  slot-1 instruction in MEM raised an exception.
- `mem_kill2_i`  in  1  slot-2 instruction in MEM raised an exception.
- `hi_o`, `lo_o`  out  W  forwarded HI/LO to both EX slots.
- `hi_arch_o`, `lo_arch_o`  out  W  architectural HI/LO, for debug and trace.

## Operation
- Per slot there are two stages: MEM (`v`, `hi`, `lo`) and WB (`v`, `hi`, `lo`). `v` is the write-valid bit.
- EX→MEM capture: `v = whilo_i`. Captured data is stored only when `v`=1; otherwise the data is don't-care and is held at 0.
- MEM→WB transfer:
  - Slot-1 `v` becomes `v & ~mem_kill1_i`.
  - Slot-2 `v` becomes `v & ~mem_kill2_i & ~mem_kill1_i`. An older exception kills the younger slot.
- WB commit writes slot 1 first, then slot 2, in the same edge. If both slots are valid, slot 2's values win.
- Each slot writes both HI and LO. Partial MTHI/MTLO merging happens in EX using `hi_o`/`lo_o`.
- Priority on every edge: `flush_i` > `stall_mem_i` > `stall_ex_i` > normal advance.
  - `flush_i`: all MEM and WB `v` are cleared, so WB commits nothing. The architectural register is unchanged except for a commit already at WB in that cycle: WB commits before the flush takes effect.
  - `stall_mem_i`: MEM holds and WB `v` is cleared after its commit.
  - `stall_ex_i`: MEM `v` is cleared, and WB loads from MEM.
- Forwarding mux (combinational), youngest valid source first: MEM slot 2, MEM slot 1, WB slot 2, WB slot 1, architectural.
- `hi_o`/`lo_o` never include same-cycle EX results. The issue logic forbids pairing a HI/LO writer with a HI/LO reader in one bundle.
- Killed MEM entries (`mem_kill*_i` high) are still forwarded in that cycle. Their consumers are flushed next cycle.

## Timing
- Reset (asynchronous): all `v` = 0, all data = 0, arch HI/LO = 0. This gives `hi_o`=`lo_o`=`hi_arch_o`=`lo_arch_o`=0.
- Write latency: a request in EX at cycle n reaches `hi_arch_o` after the edge ending cycle n+2.
- Forwarded latency: the value is visible on `hi_o` in cycle n+1, with no stalls.
- Reset asserted mid-pipeline discards all pending writes immediately.

## Configuration
- `HILO_FWD_EN` defined: the forwarding mux is built as above.
- `HILO_FWD_EN` undefined: `hi_o`/`lo_o` equal the architectural registers, and the controller must interlock readers for 2 cycles after any writer.
- Stage registers and commit order are identical in both builds.

## Structure
- `RegBus`, `RstEnable`, `WriteEnable`/`WriteDisable` and `ZeroWord` come from the shared defines header. No new global constants are added.
- One sub-module, `hilo_stage`, instantiated twice (MEM, WB). It holds one stage's two slots and takes `load`, `clear` and per-slot kill inputs.
- Commit, priority and forwarding logic live in `hilo_ctrl`.

## Test plan
- Slot-1 MTHI-style write, hi=0x1234_5678, lo=0x0 at cycle 0 → `hi_o`=0x1234_5678 at cycle 1 (MEM forward), and `hi_arch_o`=0x1234_5678 after cycle 2.
- Both slots write in one bundle (slot 1 hi=0xA, slot 2 hi=0xB) → forward and arch both show 0xB, and 0xA is never visible on `hi_arch_o`.
- Write 0x11 in cycle 0, write 0x22 in cycle 1 → in cycle 2 `hi_o`=0x22 (MEM beats WB), and arch ends at 0x22.
- Slot-1 write 0x5 with `mem_kill1_i`=1 in MEM, plus slot-2 write 0x6 in the same bundle → arch stays at its previous value and neither write commits.
- `stall_mem_i` held 3 cycles with a pending write 0x77 → arch updates exactly once, 0x77, on the edge after the stall releases and WB is reached. `hi_o`=0x77 throughout.
- `flush_i` with writes pending in MEM and WB → the WB write commits and the MEM write is discarded. `rst` pulsed mid-stream → all outputs are 0 asynchronously.
